// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data RAM with request/response handshake and fixed wait states (optional DMEM_MISALIGN_CHK_EN)
module dmem_responder #(
    parameter int ADDR_LEN    = 32,
    parameter int DATA_LEN    = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [DATA_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [DATA_LEN-1:0] resp_rdata,
    output logic                resp_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int LAST_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] LAST = LAST_I[3:0];

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_LEN-1:0]   wdata_q;
    logic [DATA_LEN-1:0]   rdata_q;
    logic [DATA_LEN-1:0]   mem [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic                  cur_we;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic [DATA_LEN-1:0]   cur_wdata;
    logic                  cur_bad;

    assign accept     = (state == S_IDLE) && req_valid;
    // With zero wait states the accept edge is also the edge entering RESP.
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == LAST));

    // In IDLE the access being accepted has not been latched yet, so use the live request.
    assign cur_we    = (state == S_IDLE) ? req_we : we_q;
    assign cur_idx   = (state == S_IDLE) ? req_addr[DEPTH_LOG2+1:2] : idx_q;
    assign cur_wdata = (state == S_IDLE) ? req_wdata : wdata_q;

`ifdef DMEM_MISALIGN_CHK_EN
    logic [1:0] lo_q;
    logic       err_q;
    logic       unused_addr;

    assign cur_bad     = ((state == S_IDLE) ? req_addr[1:0] : lo_q) != 2'b00;
    assign resp_err    = (state == S_RESP) && err_q;
    assign unused_addr = ^req_addr[ADDR_LEN-1:DEPTH_LOG2+2];

    // Latch the byte offset so a misaligned access is flagged in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q  <= 2'b00;
            err_q <= 1'b0;
        end else begin
            if (accept)
                lo_q <= req_addr[1:0];
            if (enter_resp)
                err_q <= cur_bad;
        end
    end
`else
    logic unused_addr;

    assign cur_bad     = 1'b0;
    assign resp_err    = 1'b0;
    assign unused_addr = ^{req_addr[ADDR_LEN-1:DEPTH_LOG2+2], req_addr[1:0]};
`endif

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;

    // Control FSM: accept in IDLE, count wait states, one-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        idx_q   <= req_addr[DEPTH_LOG2+1:2];
                        wdata_q <= req_wdata;
                        cnt     <= 4'd0;
                        state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == LAST) begin
                        cnt   <= 4'd0;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage: cleared by reset, written on the edge entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (enter_resp && cur_we && !cur_bad) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    // Response data: load value captured entering RESP and held until the next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= '0;
        else if (enter_resp)
            rdata_q <= (cur_we || cur_bad) ? '0 : mem[cur_idx];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        z_req_valid = 1'b0, z_req_we = 1'b0;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic        z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [256];

`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_LEN(32), .DATA_LEN(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err));

    dmem_responder #(.ADDR_LEN(32), .DATA_LEN(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .resp_valid(z_resp_valid),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err));

    // Reference: byte address -> word index modulo 256 words; misaligned accesses fail only when checked.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] exp_rdata, output logic exp_err);
        int idx;
        idx       = int'((addr / 4) % 256);
        exp_err   = CHK && ((addr % 4) != 0);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (we) model_mem[idx] = wdata;
            else    exp_rdata = model_mem[idx];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    endtask

    // Issue one request to the WAIT_CYCLES=2 instance; lat = cycles from accept to response (-1 on timeout).
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit scramble, output logic [31:0] rdata, output logic err, output int lat);
        rdata = 32'h0;
        err   = 1'b0;
        lat   = -1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (scramble) begin
                req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            end
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1)  begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        total++; if (resp_err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b exp=0", resp_err); end
        model_clear();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd, er; logic e, ee; int lat;
        model_access(1'b1, 32'h10, 32'hDEADBEEF, er, ee);
        access(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, e, lat);
        total++; if (lat !== 3)      begin bad++; $display("FAIL store_latency got=%0d exp=3", lat); end
        total++; if (rd !== 32'h0)   begin bad++; $display("FAIL store_rdata got=%h exp=0", rd); end
        model_access(1'b0, 32'h10, 32'h0, er, ee);
        access(1'b0, 32'h10, 32'h0, 1'b0, rd, e, lat);
        total++; if (lat !== 3)      begin bad++; $display("FAIL load_latency got=%0d exp=3", lat); end
        total++; if (rd !== er)      begin bad++; $display("FAIL load_rdata got=%h exp=%h", rd, er); end
        total++; if (e !== 1'b0)     begin bad++; $display("FAIL load_err got=%b exp=0", e); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, er; logic e, ee; int lat;
        model_access(1'b1, 32'h0, 32'h12345678, er, ee);
        access(1'b1, 32'h0, 32'h12345678, 1'b0, rd, e, lat);
        model_access(1'b0, 32'h400, 32'h0, er, ee);
        access(1'b0, 32'h400, 32'h0, 1'b0, rd, e, lat);
        total++; if (rd !== 32'h12345678 || lat !== 3) begin bad++; $display("FAIL wrap_load got=%h lat=%0d exp=12345678 lat=3", rd, lat); end
    endtask

    task automatic test_zero_wait();
        @(negedge clk);
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (z_resp_valid !== (i % 2 == 0) || z_req_ready !== (i % 2 != 0)) begin
                bad++; $display("FAIL zero_wait_cycle%0d got valid=%b ready=%b exp valid=%b ready=%b",
                                i, z_resp_valid, z_req_ready, (i % 2 == 0), (i % 2 != 0));
            end
        end
        z_req_valid = 1'b0;
        @(negedge clk);
        total++; if (z_resp_rdata !== 32'h0) begin bad++; $display("FAIL zero_wait_rdata got=%h exp=0", z_resp_rdata); end
    endtask

    task automatic test_ignore_changes();
        logic [31:0] rd, er; logic e, ee; int lat;
        model_access(1'b1, 32'h20, 32'hAAAA0000, er, ee);
        access(1'b1, 32'h20, 32'hAAAA0000, 1'b1, rd, e, lat);
        model_access(1'b0, 32'h20, 32'h0, er, ee);
        access(1'b0, 32'h20, 32'h0, 1'b0, rd, e, lat);
        total++; if (rd !== 32'hAAAA0000) begin bad++; $display("FAIL scramble_hold got=%h exp=aaaa0000", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, er, exp20; logic e, ee; int lat;
        model_access(1'b1, 32'h22, 32'h55, er, ee);
        access(1'b1, 32'h22, 32'h55, 1'b0, rd, e, lat);
        total++; if (e !== CHK || lat !== 3) begin bad++; $display("FAIL misalign_err got=%b lat=%0d exp=%b lat=3", e, lat, CHK); end
        exp20 = CHK ? 32'hAAAA0000 : 32'h55;
        access(1'b0, 32'h20, 32'h0, 1'b0, rd, e, lat);
        total++; if (rd !== exp20) begin bad++; $display("FAIL misalign_word20 got=%h exp=%h", rd, exp20); end
    endtask

    task automatic test_random();
        logic [31:0] rd, er, a, d; logic e, ee, w; int lat;
        for (int n = 0; n < 80; n++) begin
            w = 1'($urandom);
            a = $urandom;
            if (n % 2 == 0) a = (a & ~32'h3FC) | (32'($urandom_range(0, 7)) << 2);
            d = $urandom;
            model_access(w, a, d, er, ee);
            access(w, a, d, 1'($urandom), rd, e, lat);
            total++;
            if (rd !== er || e !== ee || lat !== 3) begin
                bad++; $display("FAIL random%0d we=%b addr=%h got=%h err=%b lat=%0d exp=%h err=%b lat=3",
                                n, w, a, rd, e, lat, er, ee);
            end
        end
    endtask

    task automatic test_mid_wait_reset();
        logic [31:0] rd, er; logic e, ee; int lat;
        model_access(1'b1, 32'h40, 32'hCAFE0001, er, ee);
        access(1'b1, 32'h40, 32'hCAFE0001, 1'b0, rd, e, lat);
        access(1'b0, 32'h40, 32'h0, 1'b0, rd, e, lat);
        total++; if (rd !== 32'hCAFE0001) begin bad++; $display("FAIL prereset_load got=%h exp=cafe0001", rd); end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h0BADF00D;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
            bad++; $display("FAIL midwait_reset got ready=%b valid=%b rdata=%h exp ready=1 valid=0 rdata=0",
                            req_ready, resp_valid, resp_rdata);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 32'h40, 32'h0, 1'b0, rd, e, lat);
        total++; if (rd !== 32'h0 || lat !== 3) begin bad++; $display("FAIL cleared_40 got=%h lat=%0d exp=0 lat=3", rd, lat); end
        access(1'b0, 32'h44, 32'h0, 1'b0, rd, e, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL lost_store_44 got=%h exp=0", rd); end
    endtask

    task automatic test_sweep();
        logic [31:0] rd, er; logic e, ee; int lat;
        for (int i = 0; i < 256; i++) begin
            model_access(1'b0, 32'(i * 4), 32'h0, er, ee);
            access(1'b0, 32'(i * 4), 32'h0, 1'b0, rd, e, lat);
            total++; if (rd !== er) begin bad++; $display("FAIL sweep_word%0d got=%h exp=%h", i, rd, er); end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wrap();
        test_zero_wait();
        test_ignore_changes();
        test_misalign();
        test_sweep();
        test_random();
        test_sweep();
        test_mid_wait_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
